uart_tx_queue: RTL

//  Byte queue between the MIPS150 UART-TX memory-mapped store path and the UART transmitter.

---
 rtl/uart_tx_queue_pkg.sv | 35 +++
 rtl/uart_tx_queue_fifo_mem.sv | 39 +++
 rtl/uart_tx_queue.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_queue_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_queue_pkg
//   Shared definitions for the MIPS150 UART transmit queue.
//   - Memory-map addresses of the UART TX data and control registers.
//   - Default queue geometry used by the memory-map decode and the queue.
//   - Byte type and the output-register load-source enumeration.
//   - Helper that forms the UART control/status word seen by the CPU.
// ----------------------------------------------------------------------------
package uart_tx_queue_pkg;

   localparam logic [31:0] UART_CTRL_ADDR    = 32'h8000_0000;
   localparam logic [31:0] UART_TX_DATA_ADDR = 32'h8000_0008;

   localparam int TXQ_DEPTH     = 16;
   localparam int TXQ_ADDR_BITS = 4;
   localparam int TXQ_DATA_W    = 8;

   typedef logic [TXQ_DATA_W-1:0] txq_byte_t;

   // Where the output register takes its next value from in a given cycle.
   typedef enum logic [1:0] {
      OB_HOLD      = 2'd0,  // UART has not taken the current byte
      OB_FROM_FIFO = 2'd1,  // refill from the head of the FIFO
      OB_BYPASS    = 2'd2,  // FIFO empty: store goes straight to the output
      OB_DRAIN     = 2'd3   // nothing to send: output becomes invalid
   } ob_src_e;

   // Control/status word: bit 0 is "TX ready" (queue not full),
   // bit 1 is "RX data valid" from the receiver side.
   function automatic logic [31:0] uart_ctrl_word(input logic tx_full,
                                                  input logic rx_valid);
      return {30'd0, rx_valid, ~tx_full};
   endfunction

endpackage

// File: rtl/uart_tx_queue_fifo_mem.sv
// ----------------------------------------------------------------------------
// tx_fifo_mem
//   DEPTH x 8 storage for the UART transmit queue. One synchronous write
//   port and one asynchronous read port, so it maps onto distributed RAM.
//   Contents are not reset; the pointer logic in the parent decides which
//   entries are meaningful.
// Ports
//   i_clk      clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write byte
//   i_rd_addr  read address
//   o_rd_data  byte at i_rd_addr (combinational)
// ----------------------------------------------------------------------------
module tx_fifo_mem
   import uart_tx_queue_pkg::*;
#(
   parameter int DEPTH     = TXQ_DEPTH,
   parameter int ADDR_BITS = TXQ_ADDR_BITS
) (
   input  logic                 i_clk,
   input  logic                 i_wr_en,
   input  logic [ADDR_BITS-1:0] i_wr_addr,
   input  txq_byte_t            i_wr_data,
   input  logic [ADDR_BITS-1:0] i_rd_addr,
   output txq_byte_t            o_rd_data
);

   txq_byte_t r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_tx_queue.sv
// ----------------------------------------------------------------------------
// uart_tx_queue
//   Byte queue between the CPU store path to the UART TX data register and
//   the UART transmitter. A DEPTH-entry FIFO feeds a one-byte output
//   register that drives the transmitter handshake, for a total capacity of
//   DEPTH+1 bytes. The CPU only needs to stall when the FIFO is full.
// Ports
//   clk          clock (only clock)
//   rst          synchronous, active-high reset
//   wr_en        CPU store of one byte
//   wr_data      byte to send
//   full         FIFO holds DEPTH bytes; further writes are dropped
//   count        bytes held in the FIFO (output register excluded)
//   ovf          sticky flag: a write was dropped while full
//   ovf_clr      clears ovf (a same-cycle drop wins)
//   tx_idle      FIFO and output register both empty
//   DataIn       byte presented to the transmitter
//   DataInValid  DataIn holds a valid byte
//   DataInReady  transmitter accepts DataIn at this posedge
// ----------------------------------------------------------------------------
module uart_tx_queue
   import uart_tx_queue_pkg::*;
#(
   parameter int DEPTH     = TXQ_DEPTH,
   parameter int ADDR_BITS = TXQ_ADDR_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [7:0]           wr_data,
   output logic                 full,
   output logic [ADDR_BITS:0]   count,
   output logic                 ovf,
   input  logic                 ovf_clr,
   output logic                 tx_idle,
   output logic [7:0]           DataIn,
   output logic                 DataInValid,
   input  logic                 DataInReady
);

   localparam logic [ADDR_BITS:0] PTR_ONE = (ADDR_BITS+1)'(1);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [ADDR_BITS:0] r_rd_ptr;
   logic [ADDR_BITS:0] r_wr_ptr;
   logic [ADDR_BITS:0] w_rd_ptr_nxt;
   logic [ADDR_BITS:0] w_wr_ptr_nxt;

   txq_byte_t r_ob;
   txq_byte_t w_ob_nxt;
   logic      r_ob_vld;
   logic      w_ob_vld_nxt;
   logic      r_ovf;
   logic      w_ovf_nxt;

   txq_byte_t w_mem_rdata;
   logic      w_empty;
   logic      w_full;
   logic      w_ob_loadable;
   logic      w_push;
   logic      w_pop;
   logic      w_drop;
   ob_src_e   w_ob_src;

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   tx_fifo_mem #(
      .DEPTH     (DEPTH),
      .ADDR_BITS (ADDR_BITS)
   ) u_mem (
      .i_clk     (clk),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wr_ptr[ADDR_BITS-1:0]),
      .i_wr_data (wr_data),
      .i_rd_addr (r_rd_ptr[ADDR_BITS-1:0]),
      .o_rd_data (w_mem_rdata)
   );

   // ------------------------------------------------------------------
   // Status from registered pointers only. Because full is not relaxed by
   // a same-cycle pop, a write in a full cycle is always dropped.
   // ------------------------------------------------------------------
   always_comb begin
      w_empty       = (r_rd_ptr == r_wr_ptr);
      w_full        = (r_rd_ptr[ADDR_BITS] != r_wr_ptr[ADDR_BITS]) &&
                      (r_rd_ptr[ADDR_BITS-1:0] == r_wr_ptr[ADDR_BITS-1:0]);
      // The output register may take a new byte if it is empty, or if the
      // transmitter is taking the current one this cycle.
      w_ob_loadable = ~r_ob_vld | DataInReady;
   end

   // ------------------------------------------------------------------
   // Output register source selection
   // ------------------------------------------------------------------
   always_comb begin
      w_ob_src = OB_HOLD;
      if (w_ob_loadable) begin
         if (!w_empty) begin
            w_ob_src = OB_FROM_FIFO;
         end else if (wr_en) begin
            w_ob_src = OB_BYPASS;
         end else begin
            w_ob_src = OB_DRAIN;
         end
      end
   end

   // ------------------------------------------------------------------
   // FIFO push/pop and next-state
   // ------------------------------------------------------------------
   always_comb begin
      w_pop  = (w_ob_src == OB_FROM_FIFO);
      // A bypassed byte goes straight to the output and never enters
      // the FIFO; otherwise any accepted write is pushed, including one
      // that coincides with a pop.
      w_push = wr_en && !w_full && (w_ob_src != OB_BYPASS);
      w_drop = wr_en && w_full;

      w_rd_ptr_nxt = w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
      w_wr_ptr_nxt = w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;

      w_ob_nxt     = r_ob;
      w_ob_vld_nxt = r_ob_vld;
      case (w_ob_src)
         OB_FROM_FIFO: begin
            w_ob_nxt     = w_mem_rdata;
            w_ob_vld_nxt = 1'b1;
         end
         OB_BYPASS: begin
            w_ob_nxt     = wr_data;
            w_ob_vld_nxt = 1'b1;
         end
         OB_DRAIN: begin
            // DataIn keeps its last value; only the valid flag drops.
            w_ob_vld_nxt = 1'b0;
         end
         default: begin
            w_ob_nxt     = r_ob;
            w_ob_vld_nxt = r_ob_vld;
         end
      endcase

      // Setting the overflow flag takes priority over clearing it.
      if (w_drop) begin
         w_ovf_nxt = 1'b1;
      end else if (ovf_clr) begin
         w_ovf_nxt = 1'b0;
      end else begin
         w_ovf_nxt = r_ovf;
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_ob     <= '0;
         r_ob_vld <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_rd_ptr <= w_rd_ptr_nxt;
         r_wr_ptr <= w_wr_ptr_nxt;
         r_ob     <= w_ob_nxt;
         r_ob_vld <= w_ob_vld_nxt;
         r_ovf    <= w_ovf_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Outputs (all derived from registers)
   // ------------------------------------------------------------------
   assign full        = w_full;
   assign count       = r_wr_ptr - r_rd_ptr;
   assign ovf         = r_ovf;
   assign tx_idle     = w_empty && !r_ob_vld;
   assign DataIn      = r_ob;
   assign DataInValid = r_ob_vld;

endmodule
